gcn_layer_scheduler: RTL and testbench

Top-level sequencer for one GCN layer. It steps the transformation stage (FM x WM), then the combination stage (COO adjacency aggregation), then the argmax/output stage, using level "go" signals and done handshakes. Once combination results exist, it also arbitrates the single read port of the FM_WM_ADJ result memory between two requesters: the argmax/output block and a host readback port. It sits above the transformation and combination blocks and drives the combination block's done_trans and index_for_read_row_out inputs.

---
 rtl/gcn_sched_pkg.sv | 5 +
 rtl/gcn_rr_arbiter2.sv | 40 ++++
 rtl/gcn_layer_scheduler.sv | 92 +++++++++
 tb/tb_gcn_layer_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gcn_sched_pkg.sv
// gcn_sched_pkg: shared state and requester types for the GCN layer scheduler
package gcn_sched_pkg;
   typedef enum logic [2:0] {IDLE, TRANS, COMB, OUT, DONE} sched_state_t;
   typedef enum logic {REQ_AM, REQ_HOST} req_id_t;
endpackage

// File: rtl/gcn_rr_arbiter2.sv
// gcn_rr_arbiter2: two-requester round-robin arbiter for the result-memory read port
// Grants are combinational; rd_valid_* is the grant delayed by the memory's one-cycle read latency.
module gcn_rr_arbiter2
   import gcn_sched_pkg::*;
#(
   parameter int ROW_IDX_BW = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  am_req,
   input  logic [ROW_IDX_BW-1:0] am_idx,
   input  logic                  host_req,
   input  logic [ROW_IDX_BW-1:0] host_idx,
   output logic                  am_gnt,
   output logic                  host_gnt,
   output logic [ROW_IDX_BW-1:0] read_row_idx,
   output logic                  rd_valid_am,
   output logic                  rd_valid_host
);
   req_id_t last_q;
   logic [ROW_IDX_BW-1:0] idx_q;
   always_comb begin
      am_gnt = en && am_req && (!host_req || last_q == REQ_HOST);
      host_gnt = en && host_req && !am_gnt;
      read_row_idx = am_gnt ? am_idx : host_gnt ? host_idx : idx_q;
   end
   always_ff @(posedge clk)
      if (reset) begin
         last_q <= REQ_HOST;
         idx_q <= '0;
         rd_valid_am <= 1'b0;
         rd_valid_host <= 1'b0;
      end else begin
         last_q <= am_gnt ? REQ_AM : host_gnt ? REQ_HOST : last_q;
         idx_q <= read_row_idx;
         rd_valid_am <= am_gnt;
         rd_valid_host <= host_gnt;
      end
endmodule

// File: rtl/gcn_layer_scheduler.sv
// gcn_layer_scheduler: steps TRANS -> COMB -> OUT for one GCN layer and arbitrates result reads
// Define GCN_SCHED_WATCHDOG_EN to abort any phase stalled for WDOG_CYCLES cycles (sets wdog_err).
module gcn_layer_scheduler
   import gcn_sched_pkg::*;
#(
   parameter int NUM_OF_NODES = 6,
   parameter int ROW_IDX_BW   = $clog2(NUM_OF_NODES),
   parameter int WDOG_CYCLES  = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  done_trans,
   input  logic                  done_comb,
   input  logic                  done_argmax,
   output logic                  trans_go,
   output logic                  comb_trans_done,
   output logic                  argmax_go,
   output logic                  busy,
   output logic                  layer_done,
   output logic                  results_valid,
   input  logic                  am_req,
   input  logic [ROW_IDX_BW-1:0] am_idx,
   input  logic                  host_req,
   input  logic [ROW_IDX_BW-1:0] host_idx,
   output logic                  am_gnt,
   output logic                  host_gnt,
   output logic [ROW_IDX_BW-1:0] read_row_idx,
   output logic                  rd_valid_am,
   output logic                  rd_valid_host,
   output logic                  wdog_err
);
   sched_state_t state, nxt;
   logic wdog_trip;
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         results_valid <= 1'b0;
      end else begin
         state <= nxt;
         results_valid <= (state == IDLE && nxt == TRANS) ? 1'b0 :
                          (state == COMB && nxt == OUT) ? 1'b1 : results_valid;
      end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = TRANS;
         TRANS:   if (done_trans) nxt = COMB;
         COMB:    if (done_comb) nxt = OUT;
         OUT:     if (done_argmax) nxt = DONE;
         default: nxt = IDLE;
      endcase
      if (wdog_trip) nxt = IDLE;
      trans_go = state == TRANS;
      comb_trans_done = state == COMB;
      argmax_go = state == OUT;
      layer_done = state == DONE;
      busy = state != IDLE;
   end
`ifdef GCN_SCHED_WATCHDOG_EN
   localparam int CW = $clog2(WDOG_CYCLES + 1);
   logic [CW-1:0] cnt;
   logic in_phase;
   assign in_phase = state inside {TRANS, COMB, OUT};
   assign wdog_trip = in_phase && cnt == CW'(WDOG_CYCLES - 1);
   always_ff @(posedge clk)
      if (reset) begin
         cnt <= '0;
         wdog_err <= 1'b0;
      end else begin
         cnt <= nxt != state ? '0 : in_phase ? cnt + 1'b1 : cnt;
         wdog_err <= wdog_err | wdog_trip;
      end
`else
   assign wdog_trip = 1'b0;
   assign wdog_err = 1'b0 & |WDOG_CYCLES;
`endif
   gcn_rr_arbiter2 #(.ROW_IDX_BW(ROW_IDX_BW)) u_arb (
      .clk(clk),
      .reset(reset),
      .en(results_valid),
      .am_req(am_req),
      .am_idx(am_idx),
      .host_req(host_req),
      .host_idx(host_idx),
      .am_gnt(am_gnt),
      .host_gnt(host_gnt),
      .read_row_idx(read_row_idx),
      .rd_valid_am(rd_valid_am),
      .rd_valid_host(rd_valid_host)
   );
endmodule

// File: tb/tb_gcn_layer_scheduler.sv
// tb_gcn_layer_scheduler: directed bench with a phase-list model compared every cycle
module tb_gcn_layer_scheduler;
   localparam int WD = 16;
`ifdef GCN_SCHED_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   logic clk = 0, reset = 1, start = 0, done_trans = 0, done_comb = 0, done_argmax = 0;
   logic am_req = 0, host_req = 0;
   logic [2:0] am_idx = 0, host_idx = 0, read_row_idx;
   logic trans_go, comb_trans_done, argmax_go, busy, layer_done, results_valid;
   logic am_gnt, host_gnt, rd_valid_am, rd_valid_host, wdog_err;
   int checks = 0, errors = 0;
   bit run = 0;

   gcn_layer_scheduler #(.NUM_OF_NODES(6), .WDOG_CYCLES(WD)) dut (
      .clk(clk), .reset(reset), .start(start), .done_trans(done_trans), .done_comb(done_comb),
      .done_argmax(done_argmax), .trans_go(trans_go), .comb_trans_done(comb_trans_done),
      .argmax_go(argmax_go), .busy(busy), .layer_done(layer_done), .results_valid(results_valid),
      .am_req(am_req), .am_idx(am_idx), .host_req(host_req), .host_idx(host_idx),
      .am_gnt(am_gnt), .host_gnt(host_gnt), .read_row_idx(read_row_idx),
      .rd_valid_am(rd_valid_am), .rd_valid_host(rd_valid_host), .wdog_err(wdog_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask

   // model: phase 0..4 = IDLE,TRANS,COMB,OUT,DONE; each phase ends on its own go/done event
   int m_ph = 0, m_cnt = 0;
   logic m_rv = 0, m_last_am = 0, m_vam = 0, m_vh = 0, m_wd = 0;
   logic [2:0] m_idx = 0;

   function automatic logic e_am();
      return m_rv && am_req && !(host_req && m_last_am);
   endfunction
   function automatic logic e_h();
      return m_rv && host_req && !e_am();
   endfunction

   always @(posedge clk) begin
      logic [4:0] ev;
      logic ga, gh;
      ga = e_am();
      gh = e_h();
      ev = {1'b1, done_argmax, done_comb, done_trans, start};
      if (reset) begin
         m_ph = 0; m_cnt = 0; m_rv = 0; m_last_am = 0; m_vam = 0; m_vh = 0; m_wd = 0; m_idx = 0;
      end else begin
         m_vam = ga;
         m_vh = gh;
         if (ga) begin m_last_am = 1; m_idx = am_idx; end
         else if (gh) begin m_last_am = 0; m_idx = host_idx; end
         if (WD_EN && m_ph >= 1 && m_ph <= 3 && m_cnt == WD - 1) begin
            m_ph = 0; m_cnt = 0; m_wd = 1;
         end else if (ev[m_ph]) begin
            if (m_ph == 0) m_rv = 0;
            if (m_ph == 2) m_rv = 1;
            m_ph = (m_ph + 1) % 5;
            m_cnt = 0;
         end else m_cnt++;
      end
   end

   always @(negedge clk) if (run) begin
      chk("trans_go", trans_go, m_ph == 1);
      chk("comb_trans_done", comb_trans_done, m_ph == 2);
      chk("argmax_go", argmax_go, m_ph == 3);
      chk("layer_done", layer_done, m_ph == 4);
      chk("busy", busy, m_ph != 0);
      chk("results_valid", results_valid, m_rv);
      chk("am_gnt", am_gnt, e_am());
      chk("host_gnt", host_gnt, e_h());
      chk("read_row_idx", read_row_idx, e_am() ? am_idx : e_h() ? host_idx : m_idx);
      chk("rd_valid_am", rd_valid_am, m_vam);
      chk("rd_valid_host", rd_valid_host, m_vh);
      chk("wdog_err", wdog_err, m_wd);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      run = 1;
      tick();
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_trans_go", trans_go, 0);
      chk("rst_results_valid", results_valid, 0);
      chk("rst_read_row_idx", read_row_idx, 0);
      tick();
      reset = 0;
      // layer 1: plan timing
      for (int c = 0; c <= 22; c++) begin
         start = c == 0; done_trans = c == 5; done_comb = c == 12; done_argmax = c == 20;
         @(negedge clk);
         if (c == 1 || c == 5) chk("l1_trans_go", trans_go, 1);
         if (c == 6) chk("l1_trans_off", trans_go, 0);
         if (c == 6 || c == 12) chk("l1_comb", comb_trans_done, 1);
         if (c == 12) chk("l1_rv_pre", results_valid, 0);
         if (c == 13 || c == 20) chk("l1_argmax_go", argmax_go, 1);
         if (c == 13) chk("l1_rv", results_valid, 1);
         if (c == 21) chk("l1_layer_done", layer_done, 1);
         if (c == 21) chk("l1_busy_done", busy, 1);
         if (c == 22) chk("l1_busy_fall", busy, 0);
         if (c == 22) chk("l1_ld_one_cycle", layer_done, 0);
         tick();
      end
      // layer 2: early host request, contention, ignored start/done_trans
      am_idx = 3; host_idx = 5;
      for (int c = 0; c <= 15; c++) begin
         start = c == 0 || c == 4; done_trans = c == 2 || c == 12;
         done_comb = c == 6; done_argmax = c == 13;
         host_req = c >= 3 && c <= 11; am_req = c >= 8 && c <= 12;
         @(negedge clk);
         if (c == 1) chk("l2_rv_clear", results_valid, 0);
         if (c >= 3 && c <= 6) chk("l2_no_gnt", host_gnt, 0);
         if (c == 7) chk("l2_host_first", host_gnt, 1);
         if (c == 8) chk("l2_rdv_host", rd_valid_host, 1);
         if (c == 8 || c == 10) chk("l2_gnt_a", am_gnt, 1);
         if (c == 9 || c == 11) chk("l2_gnt_h", host_gnt, 1);
         if (c == 8 || c == 10) chk("l2_idx_a", read_row_idx, 3);
         if (c == 9 || c == 11) chk("l2_idx_h", read_row_idx, 5);
         if (c == 9) chk("l2_rdv_am", rd_valid_am, 1);
         if (c == 12) chk("l2_argmax_held", argmax_go, 1);
         if (c == 14) chk("l2_layer_done", layer_done, 1);
         if (c == 15) chk("l2_idle", busy, 0);
         tick();
      end
      start = 0; done_trans = 0; done_comb = 0; done_argmax = 0; am_req = 0;
      // host readback after completion
      host_idx = 2;
      for (int c = 0; c <= 3; c++) begin
         host_req = c <= 2;
         @(negedge clk);
         if (c <= 2) chk("rb_host_gnt", host_gnt, 1);
         if (c == 0) chk("rb_idx", read_row_idx, 2);
         if (c == 3) chk("rb_idx_hold", read_row_idx, 2);
         tick();
      end
      // layer 3: reset in COMB
      for (int c = 0; c <= 6; c++) begin
         start = c == 0; done_trans = c == 2; reset = c == 4; host_req = c >= 3;
         @(negedge clk);
         if (c == 4) chk("l3_comb", comb_trans_done, 1);
         if (c == 5) begin
            chk("l3_rst_busy", busy, 0);
            chk("l3_rst_comb", comb_trans_done, 0);
            chk("l3_rst_rv", results_valid, 0);
            chk("l3_rst_gnt", host_gnt, 0);
         end
         tick();
      end
      host_req = 0;
      // layer 4: transformation never completes
      for (int c = 0; c <= 20; c++) begin
         start = c == 0;
         @(negedge clk);
         if (c >= 1) chk("l4_no_layer_done", layer_done, 0);
`ifdef GCN_SCHED_WATCHDOG_EN
         if (c == 16) chk("l4_trans_last", trans_go, 1);
         if (c == 17) begin
            chk("l4_wdog_err", wdog_err, 1);
            chk("l4_idle", busy, 0);
         end
`else
         if (c == 20) chk("l4_waiting", trans_go, 1);
         if (c == 20) chk("l4_no_wdog", wdog_err, 0);
`endif
         tick();
      end
      reset = 1;
      tick();
      @(negedge clk);
      chk("end_rst_wdog", wdog_err, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
